// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, frame length and the receiver state encoding.
package uart_pkg;

    localparam int BAUD_DIV_DEFAULT = 2604;  // 50 MHz / 19200 baud
    localparam int FRAME_BITS       = 10;    // start + 8 data + stop

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RX, finds the start edge, samples each bit at mid-period and
// presents the byte with sticky rdy/overrun flags and a one-cycle framing-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = ($clog2(BAUD_DIV) > 12) ? $clog2(BAUD_DIV) : 12;

    logic             rx_meta_q, rx_s_q, rx_d_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rdy_q, rdy_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic sample;
    logic fall;

    assign sample = (baud_cnt_q == '0);
    assign fall   = rx_d_q & ~rx_s_q;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rdy_d       = rdy_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        if (clr_rdy) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end

        if (state_q != IDLE) begin
            baud_cnt_d = sample ? CNT_W'(BAUD_DIV - 1) : baud_cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    baud_cnt_d = CNT_W'(HALF_DIV - 1);
                    state_d    = START;
                end
            end
            START: begin
                if (sample) begin
                    if (rx_s_q) begin
                        state_d = IDLE;  // line went back high: glitch, not a start bit
                    end else begin
                        bit_cnt_d = 3'd0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    if (rx_s_q) begin
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                        // A set coinciding with clr_rdy wins for rdy but does not flag overrun.
                        if (rdy_q && !clr_rdy) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= RX;
            rx_s_q      <= rx_meta_q;
            rx_d_q      <= rx_s_q;
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rdy       = rdy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames cycle by cycle and compares all outputs
// every cycle against a frame-level reference model of the receiver's flags and data.
module tb_uart_rx;

    localparam int DIV    = 64;
    localparam int HALF   = DIV / 2;
    localparam int FRAME  = 10 * DIV;
    // Pin driven before posedge 0 -> edge acted on at posedge 2 -> stop sample HALF + 9*DIV later.
    localparam int STOP_C = 2 + HALF + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_data;
    logic       exp_rdy, exp_ovr, exp_ferr;

    uart_rx #(.BAUD_DIV(DIV), .HALF_DIV(HALF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .clr_rdy   (clr_rdy),
        .rx_data   (rx_data),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rdy"},       {7'd0, rdy},       {7'd0, exp_rdy});
        check({tag, ".overrun"},   {7'd0, overrun},   {7'd0, exp_ovr});
        check({tag, ".rx_data"},   rx_data,           exp_data);
        check({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, exp_ferr});
    endtask

    // One clock cycle: drive pins, apply the model's view of that edge, then compare.
    // evt: 0 = nothing, 1 = good stop sample, 2 = stop bit sampled low.
    task automatic tick(input logic rx_v, input logic clr_v, input int evt,
                        input logic [7:0] b, input string tag);
        logic old_rdy;
        @(negedge clk);
        RX      = rx_v;
        clr_rdy = clr_v;
        @(posedge clk);
        old_rdy  = exp_rdy;
        exp_ferr = 1'b0;
        if (rst_n) begin
            if (clr_v) begin
                exp_rdy = 1'b0;
                exp_ovr = 1'b0;
            end
            if (evt == 1) begin
                exp_ovr  = clr_v ? 1'b0 : (exp_ovr | old_rdy);
                exp_rdy  = 1'b1;
                exp_data = b;
            end else if (evt == 2) begin
                exp_ferr = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 0, 8'h00, "idle");
    endtask

    function automatic logic line_level(input logic [7:0] b, input logic stop_bit, input int c);
        int k;
        k = c / DIV;
        if (k == 0) return 1'b0;
        if (k == 9) return stop_bit;
        return b[k-1];
    endfunction

    // Full frame; clr_at = cycle index at which clr_rdy is pulsed, -1 for none.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int clr_at);
        for (int c = 0; c < FRAME; c++) begin
            tick(line_level(b, stop_bit, c), (c == clr_at), (c == STOP_C) ? (stop_bit ? 1 : 2) : 0,
                 b, $sformatf("frame_%h_c%0d", b, c));
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop;
        int         rclr;

        rst_n    = 1'b0;
        RX       = 1'b1;
        clr_rdy  = 1'b0;
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        #3;
        check_all("reset");
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);

        // Single byte, then a lone clr_rdy.
        send_frame(8'hA5, 1'b1, -1);
        idle(4);
        tick(1'b1, 1'b1, 0, 8'h00, "clr_after_a5");
        idle(4);

        // Back-to-back frames, cleared during each stop bit.
        send_frame(8'h00, 1'b1, STOP_C + 5);
        send_frame(8'hFF, 1'b1, STOP_C + 5);
        send_frame(8'h5A, 1'b1, STOP_C + 5);
        idle(DIV);

        // Short low glitch: must be rejected at the start sample.
        for (int i = 0; i < HALF - 12; i++) tick(1'b0, 1'b0, 0, 8'h00, "glitch_low");
        idle(2 * DIV);

        // Stop bit low, then a good frame.
        send_frame(8'h3C, 1'b0, -1);
        idle(DIV);
        send_frame(8'h81, 1'b1, -1);
        idle(4);
        tick(1'b1, 1'b1, 0, 8'h00, "clr_after_81");

        // Overrun: two frames without clearing, then a clear exactly at the stop sample.
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        idle(4);
        send_frame(8'h66, 1'b1, STOP_C);
        idle(4);

        // Randomized frames: random data, clear point, stop bit and gap.
        for (int f = 0; f < 8; f++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            rclr  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, FRAME - 1));
            send_frame(rb, rstop, rclr);
            if (!rstop) idle(DIV);
            else idle($urandom_range(0, 8));
        end
        idle(4);
        send_frame(8'h9E, 1'b1, -1);  // leave rdy set with non-zero data before the reset test

        // Reset during data bit 4 of 8'hC3.
        for (int c = 0; c < 5 * DIV + 10; c++) begin
            tick(line_level(8'hC3, 1'b1, c), 1'b0, 0, 8'hC3, "c3_partial");
        end
        #2;
        rst_n    = 1'b0;
        #1;
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        check_all("reset_midframe");
        idle(3);
        @(negedge clk);
        rst_n = 1'b1;
        idle(DIV);
        send_frame(8'hC3, 1'b1, -1);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
